// File: rtl/wordline_encoder_if.sv
// rtl/wordline_encoder_if.sv - mask-in / register-ID-out handshake bundle for wordline_encoder
//   in_valid/in_ready/in_mask : 64-bit request mask, producer -> encoder
//   out_valid/out_ready/out_id: 6-bit register ID stream, encoder -> consumer
//   modport slave  : encoder view
//   modport master : producer/consumer (environment) view
interface wordline_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_mask;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_id;

  modport slave (
    input  in_valid, in_mask, out_ready,
    output in_ready, out_valid, out_id
  );

  modport master (
    output in_valid, in_mask, out_ready,
    input  in_ready, out_valid, out_id
  );
endinterface

// File: rtl/wordline_encoder.sv
// rtl/wordline_encoder.sv - serialises a 64-bit wordline mask into 6-bit register IDs, lowest first
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   bus        : wordline_encoder_if.slave (mask in, register ID out, valid/ready both sides)
//   busy       : high while emitting IDs
//   done       : one-cycle pulse after the last ID of a mask is accepted, or after a zero mask is captured
//   remain_cnt : bits still pending (only with WORDLINE_ENCODER_REMAIN_CNT_EN defined)
// Optional feature macro: WORDLINE_ENCODER_REMAIN_CNT_EN
module wordline_encoder (
  input  logic               clk,
  input  logic               rst_n,
  wordline_encoder_if.slave  bus,
  output logic               busy,
`ifdef WORDLINE_ENCODER_REMAIN_CNT_EN
  output logic               done,
  output logic [6:0]         remain_cnt
`else
  output logic               done
`endif
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t      state;
  logic [63:0] pending;
  logic [63:0] pending_next;
  logic [5:0]  low_id;
  logic        accept;
  logic        capture;

  // Priority encoder on the registered mask; the downward loop lets the
  // lowest set bit win.
  always_comb begin
    low_id = 6'd0;
    for (int i = 63; i >= 0; i--) begin
      if (pending[i]) low_id = 6'(i);
    end
  end

  // Clearing the lowest set bit: x & (x - 1).
  assign pending_next = pending & (pending - 64'd1);

  assign capture       = (state == IDLE) && bus.in_valid;
  assign accept        = (state == EMIT) && bus.out_ready;

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == EMIT);
  assign busy          = (state == EMIT);
  assign bus.out_id    = (state == EMIT) ? low_id : 6'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pending <= 64'h0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            pending <= bus.in_mask;
            if (bus.in_mask == 64'h0) done  <= 1'b1;
            else                      state <= EMIT;
          end
        end
        EMIT: begin
          // in_mask is not looked at here, so changes during EMIT are ignored.
          if (bus.out_ready) begin
            pending <= pending_next;
            if (pending_next == 64'h0) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WORDLINE_ENCODER_REMAIN_CNT_EN
  function automatic logic [6:0] popcount(input logic [63:0] m);
    logic [6:0] c;
    c = 7'd0;
    for (int i = 0; i < 64; i++) c = c + 7'(m[i]);
    return c;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       remain_cnt <= 7'd0;
    else if (capture) remain_cnt <= popcount(bus.in_mask);
    else if (accept)  remain_cnt <= remain_cnt - 7'd1;
  end
`else
  logic unused_capture;
  assign unused_capture = capture ^ accept;
`endif

endmodule

// File: tb/tb_wordline_encoder.sv
// tb/tb_wordline_encoder.sv - self-checking bench for wordline_encoder
module tb_wordline_encoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  logic done;
`ifdef WORDLINE_ENCODER_REMAIN_CNT_EN
  logic [6:0] remain_cnt;
`endif

  wordline_encoder_if bus();

  wordline_encoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .busy       (busy),
`ifdef WORDLINE_ENCODER_REMAIN_CNT_EN
    .done       (done),
    .remain_cnt (remain_cnt)
`else
    .done       (done)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [63:0] mask;
    int          n;
    logic [47:0] ids;   // expected IDs, first one in bits [5:0]
  } vec_t;

  vec_t vecs[6];

  // Drives one mask with out_ready held high and checks the ID stream and done pulse.
  task automatic run_vec(input vec_t v);
    logic [5:0] e;
    @(negedge clk);
    chk("in_ready_before", 64'(bus.in_ready), 64'd1);
    bus.in_valid  = 1'b1;
    bus.in_mask   = v.mask;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_mask  = ~v.mask;
    for (int k = 0; k < v.n; k++) begin
      e = v.ids[6*k +: 6];
      @(negedge clk);
      chk("vec_out_valid", 64'(bus.out_valid), 64'd1);
      chk("vec_out_id", 64'(bus.out_id), 64'(e));
`ifdef WORDLINE_ENCODER_REMAIN_CNT_EN
      chk("vec_remain_cnt", 64'(remain_cnt), 64'(v.n - k));
`endif
    end
    @(negedge clk);
    chk("vec_done", 64'(done), 64'd1);
    chk("vec_idle_out_valid", 64'(bus.out_valid), 64'd0);
    chk("vec_idle_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    chk("vec_done_once", 64'(done), 64'd0);
  endtask

  int seen;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_mask   = 64'h0;
    bus.out_ready = 1'b0;

    vecs[0] = '{mask: 64'h1,                   n: 1, ids: 48'(6'd0)};
    vecs[1] = '{mask: 64'h8000_0000_0000_0000, n: 1, ids: 48'(6'd63)};
    vecs[2] = '{mask: 64'h8000_0000_0001_0005, n: 4, ids: 48'({6'd63, 6'd16, 6'd2, 6'd0})};
    vecs[3] = '{mask: 64'h30,                  n: 2, ids: 48'({6'd5, 6'd4})};
    vecs[4] = '{mask: 64'h0,                   n: 0, ids: 48'd0};
    vecs[5] = '{mask: 64'hA000_0000_0000_0100, n: 3, ids: 48'({6'd63, 6'd61, 6'd8})};

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_id", 64'(bus.out_id), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
`ifdef WORDLINE_ENCODER_REMAIN_CNT_EN
    chk("rst_remain_cnt", 64'(remain_cnt), 64'd0);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Backpressure on 64'h30
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_mask  = 64'h30;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_hold_id", 64'(bus.out_id), 64'd4);
      chk("bp_hold_done", 64'(done), 64'd0);
    end
    bus.out_ready = 1'b1;
    chk("bp_id4", 64'(bus.out_id), 64'd4);
    @(negedge clk);
    chk("bp_id5", 64'(bus.out_id), 64'd5);
    chk("bp_valid5", 64'(bus.out_valid), 64'd1);
    @(negedge clk);
    chk("bp_done", 64'(done), 64'd1);
    chk("bp_idle", 64'(bus.out_valid), 64'd0);

    // All-ones mask: 64 consecutive IDs
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_mask  = {64{1'b1}};
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      chk("ones_id", 64'({bus.out_valid, bus.out_id}), 64'({1'b1, 6'(k)}));
`ifdef WORDLINE_ENCODER_REMAIN_CNT_EN
      chk("ones_remain", 64'(remain_cnt), 64'(64 - k));
`endif
    end
    @(negedge clk);
    chk("ones_done", 64'(done), 64'd1);
    chk("ones_busy", 64'(busy), 64'd0);
`ifdef WORDLINE_ENCODER_REMAIN_CNT_EN
    chk("ones_remain_end", 64'(remain_cnt), 64'd0);
`endif

    // Back-to-back 1 then 2 with in_valid held; mask change in EMIT ignored
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_mask  = 64'h1;
    @(posedge clk);
    #1 bus.in_mask = 64'h2;
    @(negedge clk);
    chk("b2b_id0", 64'({bus.out_valid, bus.out_id}), 64'({1'b1, 6'd0}));
    chk("b2b_in_ready_emit", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    chk("b2b_done1", 64'(done), 64'd1);
    chk("b2b_in_ready_done", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_id1", 64'({bus.out_valid, bus.out_id}), 64'({1'b1, 6'd1}));
    chk("b2b_no_done", 64'(done), 64'd0);
    @(negedge clk);
    chk("b2b_done2", 64'(done), 64'd1);

    // Reset mid-EMIT with 64'hF0
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_mask   = 64'hF0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    chk("mid_emit_valid", 64'(bus.out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk("post_rst_no_ids", 64'(seen), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
